mips_ctrl_fsm: RTL

MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mips_instr_decode.sv | 45 ++++
 rtl/mips_ctrl_fsm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS control FSM: opcode/funct values,
// ALU operation encodings, FSM state and instruction-class enums.
package mips_pkg;

    // Default number of MEM cycles allowed before a memory access is abandoned
    localparam int unsigned MEM_TIMEOUT_DEF = 255;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // SPECIAL funct codes
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // ALU operation codes
    localparam logic [5:0] AR_NONE = 6'b000000;
    localparam logic [5:0] AR_ADDU = 6'b100001;
    localparam logic [5:0] AR_LW   = 6'b100011;
    localparam logic [5:0] AR_SW   = 6'b101011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ADDU,
        CLS_JR,
        CLS_ADDIU,
        CLS_LW,
        CLS_SW,
        CLS_ILLEGAL
    } instr_cls_e;

    // ALU operation implied by an instruction class
    function automatic logic [5:0] ar_op_of(input instr_cls_e cls);
        case (cls)
            CLS_ADDU, CLS_ADDIU: ar_op_of = AR_ADDU;
            CLS_LW:              ar_op_of = AR_LW;
            CLS_SW:              ar_op_of = AR_SW;
            default:             ar_op_of = AR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mips_instr_decode.sv
// Purely combinational field extraction and classification of a MIPS word.
module mips_instr_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output instr_cls_e  cls_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [5:0]  shamt_o,
    output logic [31:0] imm_sext_o,
    output logic        legal_o
);

    assign rs_o       = instr_i[25:21];
    assign rt_o       = instr_i[20:16];
    assign rd_o       = instr_i[15:11];
    assign shamt_o    = {1'b0, instr_i[10:6]};
    assign imm_sext_o = {{16{instr_i[15]}}, instr_i[15:0]};
    assign legal_o    = (cls_o != CLS_ILLEGAL);

    // Classify the word; the all-zero word is a NOP even though it matches SLL
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cls_o = CLS_ILLEGAL;
        if (instr_i == 32'h0000_0000) begin
            cls_o = CLS_NOP;
        end else begin
            case (instr_i[31:26])
                OP_SPECIAL: begin
                    if (instr_i[5:0] == FN_ADDU) begin
                        cls_o = CLS_ADDU;
                    end else if (instr_i[5:0] == FN_JR) begin
                        cls_o = CLS_JR;
                    end
                end
                OP_ADDIU: cls_o = CLS_ADDIU;
                OP_LW:    cls_o = CLS_LW;
                OP_SW:    cls_o = CLS_SW;
                default:  cls_o = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: IDLE -> DECODE -> EXEC -> (MEM) -> (WB).
// Accepts one instruction at a time, sequences ALU/memory/writeback strobes,
// aborts stalled memory accesses and counts retired instructions.
module mips_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [5:0]  ar_op,
    output logic [5:0]  shift_amount,
    output logic        alu_src_imm,
    output logic [31:0] imm_sext,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic        reg_wsel_rd,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        pc_sel_jr,
    output logic        illegal,
    output logic        mem_timeout,
    output logic [15:0] retired
);

    // The MEM counter only has to hold 0 .. MEM_TIMEOUT-1
    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [31:0]      instr_q;
    logic [15:0]      retired_q, retired_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;

    instr_cls_e cls;
    logic       legal;
    logic       handshake;
    logic       mem_expire;
    logic       retire;

    mips_instr_decode u_decode (
        .instr_i    (instr_q),
        .cls_o      (cls),
        .rs_o       (rs),
        .rt_o       (rt),
        .rd_o       (rd),
        .shamt_o    (shift_amount),
        .imm_sext_o (imm_sext),
        .legal_o    (legal)
    );

    assign handshake   = instr_valid && instr_ready;
    // Ack has priority over expiry when both land in the same cycle
    assign mem_expire  = (state_q == ST_MEM) && !mem_ack && (mem_cnt_q == CNT_LAST);
    assign alu_src_imm = (cls == CLS_ADDIU) || (cls == CLS_LW) || (cls == CLS_SW);
    assign retired     = retired_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
        end
    end

    // Instruction latch, MEM cycle counter and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the instruction register is reset too, so decoded fields read as zero out of reset.
            instr_q   <= '0;
            mem_cnt_q <= '0;
            retired_q <= '0;
        end else begin
            if (handshake) begin
                instr_q <= instr;
            end
            mem_cnt_q <= mem_cnt_d;
            retired_q <= retired_d;
        end
    end

    // Counter next values: MEM counter is held at zero outside MEM, so it starts clear on entry
    always_comb begin
        mem_cnt_d = '0;
        if (state_q == ST_MEM) begin
            mem_cnt_d = mem_cnt_q + CNT_W'(1);
        end
        retired_d = retire ? (retired_q + 16'd1) : retired_q;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!legal || (cls == CLS_NOP)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls)
                    CLS_JR:         state_d = ST_IDLE;
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_d = (cls == CLS_LW) ? ST_WB : ST_IDLE;
                end else if (mem_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state and the latched instruction class
    always_comb begin
        instr_ready = 1'b0;
        ar_op       = AR_NONE;
        reg_we      = 1'b0;
        reg_wsel_rd = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        pc_sel_jr   = 1'b0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;
        retire      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
            end
            ST_DECODE: begin
                illegal = !legal;
                retire  = (cls == CLS_NOP);
            end
            ST_EXEC: begin
                ar_op     = ar_op_of(cls);
                pc_sel_jr = (cls == CLS_JR);
                retire    = (cls == CLS_JR);
            end
            ST_MEM: begin
                ar_op       = ar_op_of(cls);
                mem_req     = 1'b1;
                mem_we      = (cls == CLS_SW);
                mem_timeout = mem_expire;
                retire      = mem_ack && (cls == CLS_SW);
            end
            ST_WB: begin
                ar_op       = ar_op_of(cls);
                reg_we      = 1'b1;
                reg_wsel_rd = (cls == CLS_ADDU);
                retire      = 1'b1;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

endmodule
